spi_slave_mem: RTL and testbench

//  Synthesizable, parametrised SPI slave with circular word memory; successor to the fixed 8-bit spi_slave model.

---
 rtl/spi_slave_mem.sv | 182 ++++++++++++++++++
 tb/tb_spi_slave_mem.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_mem.sv
// SPI slave with a circular word memory. Every received word is written to
// memory at the current pointer; the reply shifted out during a word is the
// value previously held at that pointer (echo-after-fill). sck/mosi/ena are
// oversampled on clk_i, so clk_i must run at least 8x faster than sck.
module spi_slave_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  ena_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  sck_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  rx_valid_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  busy_o,
    output logic [ADDR_W-1:0]     ptr_o
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CntFull = CNT_W'(DATA_WIDTH);

    // Synchronizer chains: [0],[1] form the synchronizer, [2] is the edge-detect stage
    logic [2:0] ena_sync_q;
    logic [2:0] sck_sync_q;
    logic [1:0] mosi_sync_q;

    // Frame mode, captured on the synchronized ena rise
    logic cpol_q;
    logic cpha_q;

    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic                  skip_q, skip_d;
    logic [ADDR_W-1:0]     ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  mem_we;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic ena_rise, ena_fall, active;
    logic sck_rise, sck_fall;
    logic lead_edge, trail_edge;
    logic sample_edge, shift_edge;
    logic word_done;
    logic [ADDR_W-1:0] ptr_next;

    // Input synchronizers for the asynchronous SPI pins
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ena_sync_q  <= '0;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
        end else begin
            ena_sync_q  <= {ena_sync_q[1:0], ena_i};
            sck_sync_q  <= {sck_sync_q[1:0], sck_i};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
        end
    end

    // Edge classification in terms of the captured frame mode
    always_comb begin
        ena_rise    = ena_sync_q[1] & ~ena_sync_q[2];
        ena_fall    = ~ena_sync_q[1] & ena_sync_q[2];
        // Both stages high: edges in the rise or fall cycle itself are ignored,
        // which makes an ena fall win over a coincident final sample edge.
        active      = ena_sync_q[1] & ena_sync_q[2];
        sck_rise    = sck_sync_q[1] & ~sck_sync_q[2];
        sck_fall    = ~sck_sync_q[1] & sck_sync_q[2];
        lead_edge   = cpol_q ? sck_fall : sck_rise;
        trail_edge  = cpol_q ? sck_rise : sck_fall;
        sample_edge = active & (cpha_q ? trail_edge : lead_edge);
        shift_edge  = active & (cpha_q ? lead_edge : trail_edge);
        word_done   = (bit_cnt_q == CntFull);
        ptr_next    = ptr_q + ADDR_W'(1);
    end

    // Mode capture: cpol/cpha only take effect at the start of a frame
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
        end else if (ena_rise) begin
            cpol_q <= cpol_i;
            cpha_q <= cpha_i;
        end
    end

    // Next-state logic for shift registers, bit counter, pointer and word commit
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        skip_d     = skip_q;
        ptr_d      = ptr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        mem_we     = 1'b0;

        if (word_done) begin
            // Commit the word; the reload reads the next location, which has not
            // yet been overwritten in this pass.
            mem_we     = 1'b1;
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
            ptr_d      = ptr_next;
            bit_cnt_d  = '0;
            tx_sr_d    = mem_q[ptr_next];
            // The next shift edge either closes the last bit (cpha=0) or only
            // presents the MSB of the new word (cpha=1); neither may shift.
            skip_d     = 1'b1;
        end else if (ena_rise) begin
            bit_cnt_d = '0;
            tx_sr_d   = mem_q[ptr_q];
            // cpha=1: first leading edge presents the MSB rather than shifting
            skip_d    = cpha_i;
        end else if (ena_fall) begin
            // Partial word is dropped: no write, no pulse, pointer kept
            bit_cnt_d = '0;
        end else if (active) begin
            if (shift_edge) begin
                if (skip_q) begin
                    skip_d = 1'b0;
                end else begin
                    tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
            if (sample_edge) begin
                rx_sr_d   = {rx_sr_q[DATA_WIDTH-2:0], mosi_sync_q[1]};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    // Datapath and control registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bit_cnt_q  <= '0;
            rx_sr_q    <= '0;
            tx_sr_q    <= '0;
            skip_q     <= 1'b0;
            ptr_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            rx_sr_q    <= rx_sr_d;
            tx_sr_q    <= tx_sr_d;
            skip_q     <= skip_d;
            ptr_q      <= ptr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // Word memory, cleared on reset
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[ptr_q] <= rx_sr_q;
        end
    end

    // Outputs; miso is held low whenever the slave is not selected
    always_comb begin
        miso_o     = ena_sync_q[2] & tx_sr_q[DATA_WIDTH-1];
        rx_valid_o = rx_valid_q;
        rx_data_o  = rx_data_q;
        busy_o     = (bit_cnt_q != '0);
        ptr_o      = ptr_q;
    end

endmodule

// File: tb/tb_spi_slave_mem.sv
// Bench for spi_slave_mem: two instances (8-bit/8-deep and 16-bit/4-deep)
// driven by a bit-banged SPI master with a memory model and scoreboard queues.
module tb_spi_slave_mem;

    localparam int HALF = 8;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] ptr;
    } rx_exp_t;

    logic clk = 1'b0;
    logic rstn, ena_a, ena_b, cpol, cpha, sck, mosi;
    logic miso_a, rxv_a, busy_a;
    logic [7:0] rxd_a;
    logic [2:0] ptr_a;
    logic miso_b, rxv_b, busy_b;
    logic [15:0] rxd_b;
    logic [1:0] ptr_b;

    int n_checks = 0;
    int n_errors = 0;
    int pulses_a = 0;
    int pulses_b = 0;

    rx_exp_t     q_rx_a[$];
    rx_exp_t     q_rx_b[$];
    logic [31:0] q_tx[$];
    logic [31:0] mmem [2][8];
    int          mptr [2];

    int sel;
    int width;
    bit m_cpol, m_cpha;

    always #5 clk = ~clk;

    spi_slave_mem #(.DATA_WIDTH(8), .DEPTH(8)) u_dut_a (
        .clk_i(clk), .rstn_i(rstn), .ena_i(ena_a), .cpol_i(cpol), .cpha_i(cpha),
        .sck_i(sck), .mosi_i(mosi), .miso_o(miso_a), .rx_valid_o(rxv_a),
        .rx_data_o(rxd_a), .busy_o(busy_a), .ptr_o(ptr_a)
    );

    spi_slave_mem #(.DATA_WIDTH(16), .DEPTH(4)) u_dut_b (
        .clk_i(clk), .rstn_i(rstn), .ena_i(ena_b), .cpol_i(cpol), .cpha_i(cpha),
        .sck_i(sck), .mosi_i(mosi), .miso_o(miso_b), .rx_valid_o(rxv_b),
        .rx_data_o(rxd_b), .busy_o(busy_b), .ptr_o(ptr_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic cur_miso();
        return (sel != 0) ? miso_b : miso_a;
    endfunction

    // Received-word scoreboard, one per instance
    always @(negedge clk) begin
        if (rxv_a) begin
            rx_exp_t e;
            pulses_a++;
            if (q_rx_a.size() == 0) begin
                check_eq("rx_a_unexpected", 32'(q_rx_a.size()), 32'd1);
            end else begin
                e = q_rx_a.pop_front();
                check_eq("rx_a_data", 32'(rxd_a), e.data);
                check_eq("rx_a_ptr", 32'(ptr_a), e.ptr);
            end
        end
    end

    always @(negedge clk) begin
        if (rxv_b) begin
            rx_exp_t e;
            pulses_b++;
            if (q_rx_b.size() == 0) begin
                check_eq("rx_b_unexpected", 32'(q_rx_b.size()), 32'd1);
            end else begin
                e = q_rx_b.pop_front();
                check_eq("rx_b_data", 32'(rxd_b), e.data);
                check_eq("rx_b_ptr", 32'(ptr_b), e.ptr);
            end
        end
    end

    task automatic do_reset();
        rstn  = 1'b0;
        ena_a = 1'b0;
        ena_b = 1'b0;
        wait_clk(3);
        for (int s = 0; s < 2; s++) begin
            mptr[s] = 0;
            for (int i = 0; i < 8; i++) mmem[s][i] = '0;
        end
        q_rx_a.delete();
        q_rx_b.delete();
        q_tx.delete();
        rstn = 1'b1;
        wait_clk(4);
    endtask

    task automatic frame_start(input int s, input bit pol, input bit pha);
        sel    = s;
        width  = (s != 0) ? 16 : 8;
        m_cpol = pol;
        m_cpha = pha;
        cpol   = pol;
        cpha   = pha;
        sck    = pol;
        wait_clk(6);
        if (s != 0) ena_b = 1'b1;
        else        ena_a = 1'b1;
        wait_clk(6);
    endtask

    task automatic frame_end();
        wait_clk(12);
        ena_a = 1'b0;
        ena_b = 1'b0;
        wait_clk(8);
    endtask

    // Shift the top nbits of tx (MSB first), capturing miso as the master would
    task automatic shift_bits(input logic [31:0] tx, input int nbits, output logic [31:0] rx);
        rx = '0;
        for (int k = 0; k < nbits; k++) begin
            if (!m_cpha) begin
                mosi = tx[width-1-k];
                wait_clk(HALF);
                rx = {rx[30:0], cur_miso()};
                sck = ~m_cpol;
                wait_clk(HALF);
                sck = m_cpol;
            end else begin
                wait_clk(HALF);
                sck = ~m_cpol;
                mosi = tx[width-1-k];
                wait_clk(HALF);
                rx = {rx[30:0], cur_miso()};
                sck = m_cpol;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        rx_exp_t     e;
        logic [31:0] got;
        logic [31:0] exp;
        int          depth;
        depth  = (sel != 0) ? 4 : 8;
        e.data = w;
        e.ptr  = 32'((mptr[sel] + 1) % depth);
        if (sel != 0) q_rx_b.push_back(e);
        else          q_rx_a.push_back(e);
        q_tx.push_back(mmem[sel][mptr[sel]]);
        mmem[sel][mptr[sel]] = w;
        mptr[sel] = (mptr[sel] + 1) % depth;
        shift_bits(w, width, got);
        exp = q_tx.pop_front();
        check_eq($sformatf("miso_dut%0d_w%0h", sel, w), got, exp);
    endtask

    initial begin
        int          p0;
        logic [31:0] dummy;
        bit          pol, pha;
        logic [31:0] w;

        rstn = 1'b0; ena_a = 1'b0; ena_b = 1'b0; cpol = 1'b0; cpha = 1'b0;
        sck = 1'b0; mosi = 1'b0; sel = 0; width = 8; m_cpol = 1'b0; m_cpha = 1'b0;
        wait_clk(3);
        check_eq("rst_miso_a", 32'(miso_a), 0);
        check_eq("rst_busy_a", 32'(busy_a), 0);
        check_eq("rst_ptr_a", 32'(ptr_a), 0);
        check_eq("rst_rxv_a", 32'(rxv_a), 0);
        check_eq("rst_rxd_a", 32'(rxd_a), 0);
        check_eq("rst_ptr_b", 32'(ptr_b), 0);
        check_eq("rst_miso_b", 32'(miso_b), 0);

        // All four modes: odd-cpha modes use one frame per word, others one long frame
        for (int m = 0; m < 4; m++) begin
            pol = m[1];
            pha = m[0];
            do_reset();
            p0 = pulses_a;
            if (!pha) frame_start(0, pol, pha);
            for (int i = 0; i < 16; i++) begin
                w = (i < 8) ? 32'(i + 1) : 32'(8'hF0 + i - 8);
                if (pha) frame_start(0, pol, pha);
                send_word(w);
                if (pha) frame_end();
            end
            if (!pha) frame_end();
            check_eq($sformatf("mode%0d_pulses", m), 32'(pulses_a - p0), 32'd16);
            check_eq($sformatf("mode%0d_ptr_wrap", m), 32'(ptr_a), 32'd0);
            check_eq($sformatf("mode%0d_miso_idle", m), 32'(miso_a), 32'd0);
        end

        // Asynchronous reset in the middle of a word
        frame_start(0, 1'b0, 1'b0);
        send_word(32'h9C);
        send_word(32'hE1);
        send_word(32'h3B);
        shift_bits(32'hA5, 4, dummy);
        check_eq("busy_mid_word", 32'(busy_a), 32'd1);
        check_eq("ptr_before_rst", 32'(ptr_a), 32'd3);
        #2 rstn = 1'b0;
        #1;
        check_eq("midrst_miso", 32'(miso_a), 0);
        check_eq("midrst_busy", 32'(busy_a), 0);
        check_eq("midrst_ptr", 32'(ptr_a), 0);
        check_eq("midrst_rxv", 32'(rxv_a), 0);
        sck = 1'b0;
        do_reset();

        // ena dropped after 5 bits: nothing stored, next word lands at the same slot
        frame_start(0, 1'b0, 1'b0);
        send_word(32'h11);
        send_word(32'h22);
        frame_end();
        p0 = pulses_a;
        frame_start(0, 1'b0, 1'b0);
        shift_bits(32'hAA, 5, dummy);
        frame_end();
        check_eq("abort_ptr", 32'(ptr_a), 32'd2);
        check_eq("abort_pulses", 32'(pulses_a - p0), 32'd0);
        check_eq("abort_busy", 32'(busy_a), 32'd0);
        frame_start(0, 1'b1, 1'b1);
        send_word(32'h55);
        for (int i = 0; i < 8; i++) send_word(32'(8'h60 + i));
        frame_end();

        // Mode pins changed mid-frame are ignored; the next frame uses them
        frame_start(0, 1'b0, 1'b0);
        send_word(32'hC3);
        cpol = 1'b1;
        cpha = 1'b1;
        send_word(32'h3C);
        send_word(32'h81);
        frame_end();
        frame_start(0, 1'b1, 1'b1);
        send_word(32'h7E);
        send_word(32'h18);
        frame_end();

        // 16-bit, 4-deep instance across two passes and two modes
        do_reset();
        p0 = pulses_b;
        frame_start(1, 1'b0, 1'b0);
        send_word(32'h1234);
        send_word(32'hABCD);
        send_word(32'h0001);
        send_word(32'hFFFF);
        frame_end();
        for (int i = 0; i < 4; i++) begin
            frame_start(1, 1'b1, 1'b1);
            send_word(32'(16'h8000 >> i) | 32'h0F0F);
            frame_end();
        end
        check_eq("b_pulses", 32'(pulses_b - p0), 32'd8);
        check_eq("b_ptr_wrap", 32'(ptr_b), 32'd0);

        wait_clk(20);
        check_eq("rx_a_pending", 32'(q_rx_a.size()), 32'd0);
        check_eq("rx_b_pending", 32'(q_rx_b.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
